// File: rtl/q_update_sequencer_if.sv
// Bundle of the transition handshake, configuration, accelerator and status
// signals of the Q-update sequencer.
interface q_update_sequencer_if #(
    parameter int STATE_W  = 6,
    parameter int ACTION_W = 4,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
);
    logic                tr_valid;
    logic                tr_ready;
    logic [STATE_W-1:0]  tr_state;
    logic [ACTION_W-1:0] tr_action;
    logic [STATE_W-1:0]  tr_next_state;
    logic [DATA_W-1:0]   tr_reward;
    logic                tr_terminal;
    logic                halt;

    logic                cfg_we;
    logic                cfg_sel;
    logic [DATA_W-1:0]   cfg_data;

    logic                acc_en;
    logic [STATE_W-1:0]  acc_state;
    logic [ACTION_W-1:0] acc_action;
    logic [STATE_W-1:0]  acc_next_state;
    logic [DATA_W-1:0]   acc_reward;
    logic [DATA_W-1:0]   acc_gamma;
    logic [DATA_W-1:0]   acc_alpha;
    logic [DATA_W-1:0]   acc_result;

    logic                upd_done;
    logic [DATA_W-1:0]   upd_q;
    logic                err_action;
    logic                episode_end;
    logic [CNT_W-1:0]    step_cnt;
    logic [CNT_W-1:0]    episode_cnt;
    logic                busy;

    // The sequencer is the slave of the transition stream.
    modport slave (
        input  tr_valid, tr_state, tr_action, tr_next_state, tr_reward,
               tr_terminal, halt, cfg_we, cfg_sel, cfg_data, acc_result,
        output tr_ready, acc_en, acc_state, acc_action, acc_next_state,
               acc_reward, acc_gamma, acc_alpha, upd_done, upd_q,
               err_action, episode_end, step_cnt, episode_cnt, busy
    );

    modport master (
        output tr_valid, tr_state, tr_action, tr_next_state, tr_reward,
               tr_terminal, halt, cfg_we, cfg_sel, cfg_data, acc_result,
        input  tr_ready, acc_en, acc_state, acc_action, acc_next_state,
               acc_reward, acc_gamma, acc_alpha, upd_done, upd_q,
               err_action, episode_end, step_cnt, episode_cnt, busy
    );
endinterface

// File: rtl/q_update_sequencer.sv
// Front-end controller for the Q-learning accelerator: serialises agent
// transitions, holds the accelerator inputs through the update, and keeps stats.
module q_update_sequencer #(
    parameter int STATE_W     = 6,
    parameter int ACTION_W    = 4,
    parameter int DATA_W      = 16,
    parameter int ACC_LATENCY = 3,
    parameter int MAX_STEPS   = 100,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    q_update_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

    localparam int LAT_W = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(ACC_LATENCY - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(MAX_STEPS - 1);
    localparam logic [DATA_W-1:0] GAMMA_RST = DATA_W'(16'hE666);
    localparam logic [DATA_W-1:0] ALPHA_RST = DATA_W'(16'h1999);

    state_t              state_q;
    logic [LAT_W-1:0]    latCnt_q;
    logic                wrCycle_q;
    logic                accEn_q;
    logic [STATE_W-1:0]  accState_q;
    logic [ACTION_W-1:0] accAction_q;
    logic [STATE_W-1:0]  accNext_q;
    logic [DATA_W-1:0]   accReward_q;
    logic                terminal_q;
    logic [DATA_W-1:0]   gamma_q;
    logic [DATA_W-1:0]   alpha_q;
    logic [DATA_W-1:0]   gamma_d;
    logic [DATA_W-1:0]   alpha_d;
    logic [DATA_W-1:0]   updQ_q;
    logic                updDone_q;
    logic                errAction_q;
    logic                episodeEnd_q;
    logic [CNT_W-1:0]    stepCnt_q;
    logic [CNT_W-1:0]    episodeCnt_q;

    logic idleFree;
    logic accept;
    logic stepWrap;

    // The IDLE cycle right after COMMIT is the accelerator's write cycle, so it
    // neither accepts transitions nor takes configuration writes.
    always_comb begin
        idleFree = (state_q == IDLE) && !wrCycle_q;
        accept   = idleFree && !bus.halt && bus.tr_valid;
        stepWrap = terminal_q || (stepCnt_q == STEP_LAST);
        gamma_d  = gamma_q;
        alpha_d  = alpha_q;
        if (idleFree && bus.cfg_we) begin
            if (bus.cfg_sel) begin
                alpha_d = bus.cfg_data;
            end else begin
                gamma_d = bus.cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            latCnt_q     <= '0;
            wrCycle_q    <= 1'b0;
            accEn_q      <= 1'b0;
            accState_q   <= '0;
            accAction_q  <= '0;
            accNext_q    <= '0;
            accReward_q  <= '0;
            terminal_q   <= 1'b0;
            gamma_q      <= GAMMA_RST;
            alpha_q      <= ALPHA_RST;
            updQ_q       <= '0;
            updDone_q    <= 1'b0;
            errAction_q  <= 1'b0;
            episodeEnd_q <= 1'b0;
            stepCnt_q    <= '0;
            episodeCnt_q <= '0;
        end else begin
            gamma_q      <= gamma_d;
            alpha_q      <= alpha_d;
            updDone_q    <= 1'b0;
            errAction_q  <= 1'b0;
            episodeEnd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wrCycle_q) begin
                        wrCycle_q <= 1'b0;
                        accEn_q   <= 1'b0;
                    end else if (accept) begin
                        accState_q  <= bus.tr_state;
                        accAction_q <= bus.tr_action;
                        accNext_q   <= bus.tr_next_state;
                        accReward_q <= bus.tr_reward;
                        terminal_q  <= bus.tr_terminal;
                        if (bus.tr_action == '0) begin
                            errAction_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            accEn_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    latCnt_q <= LAT_LOAD;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    // upd_done and episode_end are raised here so they are
                    // visible during the COMMIT cycle itself.
                    if (latCnt_q == '0) begin
                        state_q      <= COMMIT;
                        updDone_q    <= 1'b1;
                        episodeEnd_q <= stepWrap;
                    end else begin
                        latCnt_q <= latCnt_q - LAT_W'(1);
                    end
                end
                COMMIT: begin
                    updQ_q    <= bus.acc_result;
                    wrCycle_q <= 1'b1;
                    state_q   <= IDLE;
                    if (stepWrap) begin
                        stepCnt_q    <= '0;
                        episodeCnt_q <= episodeCnt_q + CNT_W'(1);
                    end else begin
                        stepCnt_q <= stepCnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tr_ready       = idleFree && !bus.halt && !rst;
    assign bus.acc_en         = accEn_q;
    assign bus.acc_state      = accState_q;
    assign bus.acc_action     = accAction_q;
    assign bus.acc_next_state = accNext_q;
    assign bus.acc_reward     = accReward_q;
    assign bus.acc_gamma      = gamma_q;
    assign bus.acc_alpha      = alpha_q;
    assign bus.upd_done       = updDone_q;
    assign bus.upd_q          = updQ_q;
    assign bus.err_action     = errAction_q;
    assign bus.episode_end    = episodeEnd_q;
    assign bus.step_cnt       = stepCnt_q;
    assign bus.episode_cnt    = episodeCnt_q;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_q_update_sequencer.sv
// Self-checking bench for q_update_sequencer: directed and random transitions
// against a transaction-level model of commits, episodes and configuration.
module tb_q_update_sequencer;
   localparam int STATE_W       = 6;
   localparam int ACTION_W      = 4;
   localparam int DATA_W        = 16;
   localparam int ACC_LATENCY   = 3;
   localparam int MAX_STEPS     = 3;
   localparam int CNT_W         = 16;
   localparam int COMMIT_DELAY  = ACC_LATENCY + 2;
   localparam int EN_CYCLES     = ACC_LATENCY + 3;
   localparam int ACCEPT_PERIOD = ACC_LATENCY + 4;

   typedef struct {
      logic [15:0] q;
      logic        epEnd;
      int          step;
      int          ep;
      int          acceptCyc;
   } commit_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   enCount = 0;
   int   lastAccept = 0;

   commit_t     expQ[$];
   int          mStep;
   int          mEp;
   logic [15:0] mGamma;
   logic [15:0] mAlpha;

   always #5 clock = ~clock;

   q_update_sequencer_if #(
      .STATE_W(STATE_W), .ACTION_W(ACTION_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
   ) bus ();

   q_update_sequencer #(
      .STATE_W(STATE_W), .ACTION_W(ACTION_W), .DATA_W(DATA_W),
      .ACC_LATENCY(ACC_LATENCY), .MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W)
   ) dut (
      .clk(clock),
      .rst(reset),
      .bus(bus)
   );

   // Arbitrary mixing function standing in for the accelerator's Q update.
   function automatic logic [15:0] qHash(input logic [5:0] s, input logic [3:0] a,
                                         input logic [5:0] ns, input logic [15:0] r,
                                         input logic [15:0] g, input logic [15:0] al);
      return (r ^ {s, a, ns}) + (g >> 3) + (al << 1);
   endfunction

   // Accelerator model: the result is only valid once acc_en has been high for ACC_LATENCY edges.
   always @(posedge clock) begin
      cyc++;
      enCount <= bus.acc_en ? enCount + 1 : 0;
   end

   assign bus.acc_result = (enCount >= ACC_LATENCY)
                         ? qHash(bus.acc_state, bus.acc_action, bus.acc_next_state,
                                 bus.acc_reward, bus.acc_gamma, bus.acc_alpha)
                         : 16'hDEAD;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Commit monitor: every upd_done must match the oldest expected commit.
   commit_t     cur;
   logic        pending = 1'b0;
   int          runLen = 0;
   logic [5:0]  runState;
   logic [3:0]  runAction;

   always @(negedge clock) begin
      if (pending) begin
         checkOutput("upd_q", bus.upd_q, cur.q);
         checkOutput("step_cnt", bus.step_cnt, cur.step);
         checkOutput("episode_cnt", bus.episode_cnt, cur.ep);
         pending = 1'b0;
      end
      if (bus.upd_done) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_upd_done", {31'b0, bus.upd_done}, 0);
         end else begin
            cur = expQ.pop_front();
            checkOutput("upd_done_latency", cyc - cur.acceptCyc, COMMIT_DELAY);
            checkOutput("episode_end", {31'b0, bus.episode_end}, {31'b0, cur.epEnd});
            pending = 1'b1;
         end
      end else begin
         checkOutput("episode_end_quiet", {31'b0, bus.episode_end}, 0);
      end
      if (bus.acc_en) begin
         if (runLen == 0) begin
            runState  = bus.acc_state;
            runAction = bus.acc_action;
         end else begin
            checkOutput("acc_state_stable", bus.acc_state, runState);
            checkOutput("acc_action_stable", bus.acc_action, runAction);
         end
         runLen++;
      end else if (runLen != 0) begin
         if (!reset) checkOutput("acc_en_cycles", runLen, EN_CYCLES);
         runLen = 0;
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic resetModel();
      expQ.delete();
      mStep  = 0;
      mEp    = 0;
      mGamma = 16'hE666;
      mAlpha = 16'h1999;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      checkOutput("tr_ready_in_reset", {31'b0, bus.tr_ready}, 0);
      tick();
      reset = 1'b0;
      resetModel();
      tick();
   endtask

   // Offer one transition, wait for its accept, and record the expected commit.
   task automatic applyStimulus(input logic [5:0] s, input logic [3:0] a, input logic [5:0] ns,
                                input logic [15:0] r, input logic term, input logic hold);
      commit_t e;
      int      waitCnt;
      bus.tr_state      = s;
      bus.tr_action     = a;
      bus.tr_next_state = ns;
      bus.tr_reward     = r;
      bus.tr_terminal   = term;
      bus.tr_valid      = 1'b1;
      waitCnt = 0;
      while (!bus.tr_ready && waitCnt < 60) begin
         tick();
         waitCnt++;
      end
      if (!bus.tr_ready) begin
         checkOutput("accept_timeout", {31'b0, bus.tr_ready}, 1);
         bus.tr_valid = 1'b0;
         return;
      end
      lastAccept = cyc;
      if (a != 0) begin
         e.q = qHash(s, a, ns, r, mGamma, mAlpha);
         if (term || mStep == MAX_STEPS - 1) begin
            mStep   = 0;
            mEp     = mEp + 1;
            e.epEnd = 1'b1;
         end else begin
            mStep   = mStep + 1;
            e.epEnd = 1'b0;
         end
         e.step      = mStep;
         e.ep        = mEp;
         e.acceptCyc = cyc;
         expQ.push_back(e);
      end
      tick();
      checkOutput("err_action", {31'b0, bus.err_action}, (a == 0) ? 1 : 0);
      if (!hold) bus.tr_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || pending || bus.busy || bus.acc_en) && n < 60) begin
         tick();
         n++;
      end
      checkOutput("idle_busy_en", {30'b0, bus.busy, bus.acc_en}, 0);
      checkOutput("pending_commits", expQ.size(), 0);
   endtask

   initial begin
      int prev;
      int seen;
      logic [15:0] newAlpha;
      bus.tr_valid = 1'b0; bus.tr_state = '0; bus.tr_action = '0; bus.tr_next_state = '0;
      bus.tr_reward = '0; bus.tr_terminal = 1'b0; bus.halt = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_data = '0;
      resetModel();

      doReset();
      checkOutput("rst_tr_ready", {31'b0, bus.tr_ready}, 1);
      checkOutput("rst_gamma", bus.acc_gamma, 16'hE666);
      checkOutput("rst_alpha", bus.acc_alpha, 16'h1999);
      checkOutput("rst_acc_en", {31'b0, bus.acc_en}, 0);
      checkOutput("rst_step", bus.step_cnt, 0);
      checkOutput("rst_episode", bus.episode_cnt, 0);
      checkOutput("rst_busy", {31'b0, bus.busy}, 0);
      checkOutput("rst_upd_q", bus.upd_q, 0);

      $display("[TB] single transition");
      applyStimulus(6'd5, 4'd3, 6'd9, 16'h0100, 1'b0, 1'b0);
      waitIdle();
      checkOutput("t1_step", bus.step_cnt, 1);

      $display("[TB] back-to-back transitions");
      for (int i = 0; i < 4; i++) begin
         prev = lastAccept;
         applyStimulus(6'($urandom), 4'($urandom_range(1, 15)), 6'($urandom),
                       16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         if (i > 0) checkOutput("accept_period", lastAccept - prev, ACCEPT_PERIOD);
      end
      bus.tr_valid = 1'b0;
      waitIdle();

      $display("[TB] episode rollover");
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(6'($urandom), 4'($urandom_range(1, 15)), 6'($urandom),
                       16'($urandom), 1'b0, 1'b1);
      end
      bus.tr_valid = 1'b0;
      waitIdle();
      checkOutput("t3_step", bus.step_cnt, 1);
      checkOutput("t3_episode", bus.episode_cnt, 2);

      $display("[TB] action zero dropped");
      applyStimulus(6'd1, 4'd0, 6'd2, 16'h0042, 1'b0, 1'b0);
      checkOutput("t4_acc_en", {31'b0, bus.acc_en}, 0);
      checkOutput("t4_tr_ready", {31'b0, bus.tr_ready}, 1);
      checkOutput("t4_step", bus.step_cnt, mStep);
      tick();
      checkOutput("t4_err_once", {31'b0, bus.err_action}, 0);
      checkOutput("t4_busy", {31'b0, bus.busy}, 0);

      $display("[TB] configuration writes");
      applyStimulus(6'($urandom), 4'($urandom_range(1, 15)), 6'($urandom), 16'($urandom), 1'b0, 1'b0);
      tick();
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_data = 16'h8000;
      tick();
      bus.cfg_we = 1'b0;
      checkOutput("t5_gamma_ignored", bus.acc_gamma, 16'hE666);
      waitIdle();
      bus.cfg_we = 1'b1;
      tick();
      bus.cfg_we = 1'b0;
      mGamma = 16'h8000;
      checkOutput("t5_gamma_written", bus.acc_gamma, 16'h8000);
      newAlpha = 16'($urandom);
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_data = newAlpha;
      mAlpha = newAlpha;
      applyStimulus(6'($urandom), 4'($urandom_range(1, 15)), 6'($urandom), 16'($urandom), 1'b0, 1'b0);
      bus.cfg_we = 1'b0;
      checkOutput("t5_alpha_written", bus.acc_alpha, newAlpha);
      waitIdle();

      $display("[TB] halt behaviour");
      applyStimulus(6'($urandom), 4'($urandom_range(1, 15)), 6'($urandom), 16'($urandom), 1'b0, 1'b0);
      bus.halt = 1'b1;
      waitIdle();
      bus.tr_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.tr_ready || bus.busy) seen++;
      end
      checkOutput("halt_blocks_accept", seen, 0);
      bus.tr_valid = 1'b0;
      bus.halt = 1'b0;
      tick();

      $display("[TB] reset during WAIT");
      applyStimulus(6'($urandom), 4'($urandom_range(1, 15)), 6'($urandom), 16'($urandom), 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("t6_busy", {31'b0, bus.busy}, 0);
      checkOutput("t6_acc_en", {31'b0, bus.acc_en}, 0);
      checkOutput("t6_step", bus.step_cnt, 0);
      checkOutput("t6_alpha", bus.acc_alpha, 16'h1999);
      checkOutput("t6_gamma", bus.acc_gamma, 16'hE666);
      reset = 1'b0;
      resetModel();
      for (int i = 0; i < 10; i++) tick();
      checkOutput("t6_step_after", bus.step_cnt, 0);

      $display("[TB] random transitions");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(6'($urandom), 4'($urandom_range(0, 15)), 6'($urandom), 16'($urandom),
                       1'($urandom_range(0, 3) == 0), 1'b0);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
      waitIdle();
      checkOutput("final_step", bus.step_cnt, mStep);
      checkOutput("final_episode", bus.episode_cnt, mEp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
